// File: rtl/logical_tile_io_bank_iopad_cfg_if.sv
// Configuration-chain and fabric-side signals of the multi-pad I/O tile.
// The physical pads stay a plain inout port on the tile itself.
interface logical_tile_io_bank_iopad_cfg_if #(
  parameter int NUM_PADS = 4
);
  localparam int CHAIN_LEN = 2 * NUM_PADS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

  logic                ccff_head;
  logic                ccff_shift_en;
  logic                cfg_commit;
  logic [NUM_PADS-1:0] iopad_outpad;
  logic [NUM_PADS-1:0] iopad_inpad;
  logic                ccff_tail;
  logic                cfg_loaded;
  logic                cfg_err;
  logic [CNT_W-1:0]    cfg_count;

  modport master (
    output ccff_head, ccff_shift_en, cfg_commit, iopad_outpad,
    input  iopad_inpad, ccff_tail, cfg_loaded, cfg_err, cfg_count
  );

  modport slave (
    input  ccff_head, ccff_shift_en, cfg_commit, iopad_outpad,
    output iopad_inpad, ccff_tail, cfg_loaded, cfg_err, cfg_count
  );
endinterface

// File: rtl/logical_tile_io_bank_iopad_cfg.sv
// Multi-pad GPIO tile: per-pad direction/invert bits are staged in a scan chain
// and reach the pads only on a length-checked commit into a shadow register.
module logical_tile_io_bank_iopad_cfg #(
  parameter int NUM_PADS = 4
) (
  input  logic                             prog_clk,
  input  logic                             pReset,
  logical_tile_io_bank_iopad_cfg_if.slave  cfg,
  inout  wire  [NUM_PADS-1:0]              gfpga_pad_GPIO_PAD
);
  localparam int CHAIN_LEN = 2 * NUM_PADS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [NUM_PADS-1:0]  dir_q, dir_d;
  logic [NUM_PADS-1:0]  inv_q, inv_d;
  logic [NUM_PADS-1:0]  sr_dir, sr_inv;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic                 commit_ok;

  // Even chain bits are direction, odd bits are polarity invert.
  always_comb begin
    sr_dir = '0;
    sr_inv = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      sr_dir[p] = sr_q[2*p];
      sr_inv[p] = sr_q[2*p+1];
    end
  end

  // The commit check looks at the pre-cycle count, so a shift in the same
  // cycle cannot turn a short load into an accepted one.
  assign commit_ok = cfg.cfg_commit && (cnt_q == CNT_FULL);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the branches below can leave one unassigned and infer a latch.
    sr_d     = sr_q;
    dir_d    = dir_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    err_d    = err_q;

    if (cfg.ccff_shift_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], cfg.ccff_head};
    end

    if (cfg.cfg_commit) begin
      cnt_d = cfg.ccff_shift_en ? CNT_W'(1) : '0;
      if (commit_ok) begin
        dir_d    = sr_dir;
        inv_d    = sr_inv;
        loaded_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg.ccff_shift_en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers update with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      // NOTE: the staging chain is reset too, so ccff_tail is known right
      // after reset instead of leaking stale bits into the next tile.
      sr_q     <= '0;
      dir_q    <= '1;
      inv_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      dir_q    <= dir_d;
      inv_q    <= inv_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign gfpga_pad_GPIO_PAD[p] = dir_q[p] ? 1'bz : (cfg.iopad_outpad[p] ^ inv_q[p]);
  end

  assign cfg.iopad_inpad = gfpga_pad_GPIO_PAD ^ inv_q;
  assign cfg.ccff_tail   = sr_q[CHAIN_LEN-1];
  assign cfg.cfg_loaded  = loaded_q;
  assign cfg.cfg_err     = err_q;
  assign cfg.cfg_count   = cnt_q;
endmodule
